// File: rtl/tile_access_arbiter.sv
// tile_access_arbiter
//   Shares one single-port tile store (wall bit + dot bit per tile) between NUM_REQ movers.
//   Requester 0 is the player and the rest are ghosts. Requests are served round-robin, one
//   transaction every four cycles: IDLE (grant + read) -> READ -> WAIT (capture + respond,
//   optional dot clear) -> RESP -> IDLE. All outputs are registered.
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   req/req_idx/req_clr   per-requester level request, tile index slice, eat-dot flag
//   gnt                   one-hot grant pulse
//   rsp_valid/rsp_id      response strobe and the requester it belongs to
//   rsp_wall/rsp_dot      looked-up flags (dot as it was before any clear)
//   mem_rd/mem_addr       tile store read strobe and address
//   mem_wall/mem_dot      read data, valid the cycle after mem_rd is sampled
//   mem_dot_clr           write strobe: clear dot at mem_addr
//   dot_eaten             pulse per dot actually cleared (score feed)
module tile_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 24,
  parameter int unsigned IDX_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ-1:0]       req_clr,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic                     rsp_wall,
  output logic                     rsp_dot,
  output logic                     mem_rd,
  output logic [IDX_W-1:0]         mem_addr,
  input  logic                     mem_wall,
  input  logic                     mem_dot,
  output logic                     mem_dot_clr,
  output logic                     dot_eaten
);

  localparam logic [IDX_W:0] NumTiles = (IDX_W + 1)'(COLS * ROWS);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic               clr_q, clr_d;
  logic               oor_q, oor_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               mem_rd_q, mem_rd_d;
  logic [IDX_W-1:0]   mem_addr_q, mem_addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2:0]         rsp_id_q, rsp_id_d;
  logic               rsp_wall_q, rsp_wall_d;
  logic               rsp_dot_q, rsp_dot_d;
  logic               mem_dot_clr_q, mem_dot_clr_d;
  logic               dot_eaten_q, dot_eaten_d;

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  logic               pick_found;
  logic [2:0]         pick_id;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_clr;
  logic [NUM_REQ-1:0] pick_onehot;
  int unsigned        cand;

  always_comb begin
    pick_found  = 1'b0;
    pick_id     = '0;
    pick_idx    = '0;
    pick_clr    = 1'b0;
    pick_onehot = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!pick_found && req[cand]) begin
        pick_found        = 1'b1;
        pick_id           = 3'(cand);
        pick_idx          = req_idx[cand*IDX_W +: IDX_W];
        pick_clr          = req_clr[cand];
        pick_onehot[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    clr_d         = clr_q;
    oor_d         = oor_q;
    mem_addr_d    = mem_addr_q;
    rsp_id_d      = rsp_id_q;
    rsp_wall_d    = rsp_wall_q;
    rsp_dot_d     = rsp_dot_q;
    // Strobes last exactly one state, so they default low.
    gnt_d         = '0;
    mem_rd_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    mem_dot_clr_d = 1'b0;
    dot_eaten_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          id_d    = pick_id;
          clr_d   = pick_clr;
          gnt_d   = pick_onehot;
          ptr_d   = (pick_id == 3'(NUM_REQ - 1)) ? 3'd0 : pick_id + 3'd1;
          if ({1'b0, pick_idx} < NumTiles) begin
            oor_d      = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = pick_idx;
          end else begin
            oor_d = 1'b1;
          end
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StWait;
      end
      StWait: begin
        // Off-board tiles behave as solid wall without a dot.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_wall_d  = oor_q | mem_wall;
        rsp_dot_d   = ~oor_q & mem_dot;
        if (clr_q && mem_dot && !oor_q) begin
          mem_dot_clr_d = 1'b1;
          dot_eaten_d   = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      id_q          <= '0;
      clr_q         <= 1'b0;
      oor_q         <= 1'b0;
      gnt_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_wall_q    <= 1'b0;
      rsp_dot_q     <= 1'b0;
      mem_dot_clr_q <= 1'b0;
      dot_eaten_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      clr_q         <= clr_d;
      oor_q         <= oor_d;
      gnt_q         <= gnt_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_wall_q    <= rsp_wall_d;
      rsp_dot_q     <= rsp_dot_d;
      mem_dot_clr_q <= mem_dot_clr_d;
      dot_eaten_q   <= dot_eaten_d;
    end
  end

  assign gnt         = gnt_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_wall    = rsp_wall_q;
  assign rsp_dot     = rsp_dot_q;
  assign mem_dot_clr = mem_dot_clr_q;
  assign dot_eaten   = dot_eaten_q;

endmodule
